// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, the single instruction-memory port and
// the IF_ID pipeline register. It loads the program, runs the fetch loop, and halts.
module fetch_ctrl #(
   parameter int          IMEM_DEPTH = 128,
   parameter logic [31:0] RESET_PC   = 32'd0,
   localparam int         AW         = $clog2(IMEM_DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load_valid,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          load_done,
   output logic          load_ready,
   output logic [AW-1:0] imem_addr,
   output logic          imem_we,
   output logic [31:0]   imem_wdata,
   input  logic [31:0]   imem_rdata,
   input  logic          stall,
   input  logic          branch_valid,
   input  logic [31:0]   branch_target,
   output logic [63:0]   IF_ID,
   output logic          if_id_valid,
   output logic [31:0]   pc,
   output logic [1:0]    state,
   output logic          halt_err
);

   typedef enum logic [1:0] {
      ST_LOAD = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);
   localparam logic [31:0] LAST_PC = DEPTH_W - 32'd1;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [63:0] if_id_q, if_id_d;
   logic        valid_q, valid_d;
   logic        halt_err_q, halt_err_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_LOAD;
         pc_q       <= RESET_PC;
         if_id_q    <= '0;
         valid_q    <= 1'b0;
         halt_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_id_q    <= if_id_d;
         valid_q    <= valid_d;
         halt_err_q <= halt_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_id_d    = if_id_q;
      valid_d    = valid_q;
      halt_err_d = halt_err_q;
      case (state_q)
         ST_LOAD: begin
            if_id_d = '0;
            valid_d = 1'b0;
            if (load_done) begin
               state_d = ST_RUN;
               pc_d    = RESET_PC;
            end
         end
         ST_RUN: begin
            // A redirect always wins over stall and always leaves a bubble.
            if (branch_valid) begin
               valid_d = 1'b0;
               if (branch_target < DEPTH_W) begin
                  pc_d = branch_target;
               end else begin
                  state_d    = ST_HALT;
                  halt_err_d = 1'b1;
               end
            end else if (!stall) begin
               if_id_d = {pc_q, imem_rdata};
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd1;
               if (pc_q == LAST_PC) begin
                  state_d = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            // Decode takes the final instruction on the first HALT cycle, stall or not.
            valid_d = 1'b0;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   assign load_ready  = (state_q == ST_LOAD);
   assign imem_we     = load_valid && (state_q == ST_LOAD);
   assign imem_addr   = (state_q == ST_LOAD) ? load_addr : pc_q[AW-1:0];
   assign imem_wdata  = load_data;
   assign IF_ID       = if_id_q;
   assign if_id_valid = valid_q;
   assign pc          = pc_q;
   assign state       = state_q;
   assign halt_err    = halt_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural instruction memory plus a queue of
// expected IF_ID words, popped whenever the block presents a valid instruction.
module tb_fetch_ctrl;
   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic          clock = 1'b0;
   logic          reset;
   logic          load_valid;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;
   logic          load_done;
   logic          load_ready;
   logic [AW-1:0] imem_addr;
   logic          imem_we;
   logic [31:0]   imem_wdata;
   logic [31:0]   imem_rdata;
   logic          stall;
   logic          branch_valid;
   logic [31:0]   branch_target;
   logic [63:0]   IF_ID;
   logic          if_id_valid;
   logic [31:0]   pc;
   logic [1:0]    state;
   logic          halt_err;

   logic [31:0] mem [DEPTH];
   logic [63:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   always @(posedge clock) if (imem_we) mem[imem_addr] <= imem_wdata;
   assign imem_rdata = mem[imem_addr];

   fetch_ctrl #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
      .clock(clock), .reset(reset),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .load_done(load_done), .load_ready(load_ready),
      .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
      .imem_rdata(imem_rdata), .stall(stall),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .IF_ID(IF_ID), .if_id_valid(if_id_valid), .pc(pc),
      .state(state), .halt_err(halt_err)
   );

   function automatic logic [31:0] prog_word(input int a);
      case (a)
         0: return 32'd11;
         1: return 32'd22;
         2: return 32'd33;
         3: return 32'd44;
         default: return 32'h5A00_0000 | 32'(a);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Push the expected instruction, clock once, then pop against the DUT output.
   task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input string tag);
      logic [63:0] e;
      exp_q.push_back({a, d});
      tick();
      chk({tag, "_valid"}, {63'd0, if_id_valid}, 64'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, IF_ID, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
         e = exp_q.pop_front();
         chk(tag, IF_ID, e);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
      load_done = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
      tick();
      // Stall and branch must be ignored while in reset / LOAD.
      stall = 1'b1; branch_valid = 1'b1; branch_target = 32'd5;
      tick();
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_ifid", IF_ID, 64'd0);
      chk("rst_valid", 64'(if_id_valid), 64'd0);
      chk("rst_halt_err", 64'(halt_err), 64'd0);
      chk("rst_load_ready", 64'(load_ready), 64'd1);
      reset = 1'b1;
      tick();
      chk("load_pc_after_branch", 64'(pc), 64'd0);
      stall = 1'b0; branch_valid = 1'b0;

      for (int a = 0; a < DEPTH; a++) begin
         load_valid = 1'b1; load_addr = AW'(a); load_data = prog_word(a);
         if (a == 0) begin
            #1;
            chk("load_we", 64'(imem_we), 64'd1);
         end
         tick();
      end
      load_valid = 1'b0;
      chk("load_mem3", 64'(mem[3]), 64'd44);

      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      chk("run_state", 64'(state), 64'd1);
      chk("run_pc", 64'(pc), 64'd0);
      chk("run_we", 64'(imem_we), 64'd0);

      fetch_one(32'd0, 32'd11, "fetch0");
      fetch_one(32'd1, 32'd22, "fetch1");

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ifid", IF_ID, {32'd1, 32'd22});
         chk("stall_pc", 64'(pc), 64'd2);
      end
      stall = 1'b0;
      fetch_one(32'd2, 32'd33, "fetch2");
      fetch_one(32'd3, 32'd44, "fetch3");

      branch_valid = 1'b1; branch_target = 32'h10; stall = 1'b1;
      tick();
      branch_valid = 1'b0; stall = 1'b0;
      chk("br_pc", 64'(pc), 64'h10);
      chk("br_bubble", 64'(if_id_valid), 64'd0);
      chk("br_ifid_held", IF_ID, {32'd3, 32'd44});
      fetch_one(32'h10, prog_word(16), "br_target");

      for (int a = 17; a < DEPTH; a++) begin
         fetch_one(32'(a), prog_word(a), "run");
      end
      chk("last_state", 64'(state), 64'd2);
      stall = 1'b1;
      tick();
      chk("halt_valid", 64'(if_id_valid), 64'd0);
      chk("halt_pc", 64'(pc), 64'd128);
      chk("halt_ifid", IF_ID, {32'd127, prog_word(127)});
      tick();
      stall = 1'b0;
      chk("halt_pc2", 64'(pc), 64'd128);
      chk("halt_state2", 64'(state), 64'd2);
      chk("halt_err_clear", 64'(halt_err), 64'd0);

      do_reset();
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      fetch_one(32'd0, 32'd11, "rerun0");
      branch_valid = 1'b1; branch_target = 32'd200;
      tick();
      branch_valid = 1'b0;
      chk("bad_br_state", 64'(state), 64'd2);
      chk("bad_br_err", 64'(halt_err), 64'd1);
      chk("bad_br_valid", 64'(if_id_valid), 64'd0);
      tick();
      chk("bad_br_err_sticky", 64'(halt_err), 64'd1);
      do_reset();
      chk("rst2_state", 64'(state), 64'd0);
      chk("rst2_err", 64'(halt_err), 64'd0);
      chk("rst2_pc", 64'(pc), 64'd0);
      chk("rst2_load_ready", 64'(load_ready), 64'd1);

      load_valid = 1'b1; load_done = 1'b1; load_addr = '0; load_data = 32'hAA;
      tick();
      load_valid = 1'b0; load_done = 1'b0;
      chk("same_edge_state", 64'(state), 64'd1);
      chk("same_edge_mem0", 64'(mem[0]), 64'hAA);
      fetch_one(32'd0, 32'hAA, "same_edge_fetch");
      fetch_one(32'd1, 32'd22, "same_edge_fetch1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage: owns the program counter, the single instruction-memory port and the 64-bit IF_ID pipeline register. After reset it lets a program loader write instruction memory, then fetches one instruction per cycle into IF_ID, honouring downstream stalls and branch redirects, and halts at the end of memory or on an illegal branch target. It sits between the instruction memory and the decode stage, and replaces free-running PC logic in the fetch path.

## Interface

Parameters:
- IMEM_DEPTH, 128, instruction-memory words; power of two; AW = log2(IMEM_DEPTH)
- RESET_PC, 0, PC value loaded at reset and at LOAD→RUN

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; 0 on a rising edge resets the block
- load_valid  in  1  loader write request
- load_addr  in  AW  loader word address
- load_data  in  32  loader write data
- load_done  in  1  loader finished; leave LOAD
- load_ready  out  1  1 iff state==LOAD (combinational)
- imem_addr  out  AW  memory address: load_addr in LOAD, pc[AW-1:0] otherwise
- imem_we  out  1  load_valid & (state==LOAD)
- imem_wdata  out  32  load_data
- imem_rdata  in  32  combinational read data for imem_addr
- stall  in  1  decode cannot accept; hold IF_ID
- branch_valid  in  1  redirect request
- branch_target  in  32  redirect word address
- IF_ID  out  64  [63:32] PC of instruction, [31:0] instruction
- if_id_valid  out  1  IF_ID holds a real instruction
- pc  out  32  next fetch address
- state  out  2  00 LOAD, 01 RUN, 10 HALT
- halt_err  out  1  sticky; set on out-of-range branch target

## Operation

- Reset (reset==0 at clock edge): state=LOAD, pc=RESET_PC, IF_ID=0, if_id_valid=0, halt_err=0. Overrides all other inputs.
- LOAD: each cycle with load_valid=1 writes load_data to load_addr (imem_we=1). stall and branch inputs ignored; IF_ID and if_id_valid stay 0. load_done=1 → RUN next cycle, pc=RESET_PC. load_valid and load_done in the same cycle: the write is performed and the transition happens.
- RUN, priority per cycle:
  1. branch_valid=1, branch_target < IMEM_DEPTH: pc<=branch_target, if_id_valid<=0 (bubble), IF_ID unchanged. Branch beats stall.
  2. branch_valid=1, branch_target ≥ IMEM_DEPTH: state<=HALT, halt_err<=1, if_id_valid<=0.
  3. stall=1: pc, IF_ID, if_id_valid held.
  4. otherwise: IF_ID<={pc, imem_rdata}, if_id_valid<=1, pc<=pc+1. If the fetched pc == IMEM_DEPTH-1, state<=HALT the same edge (last instruction is still latched as valid).
- RUN ignores load_valid/load_done; imem_we=0.
- HALT: pc and IF_ID frozen; if_id_valid<=0 on the first HALT cycle, which is also the first cycle decode may consume the last instruction (a stall then is not honoured). Only reset exits HALT.
- pc arithmetic is 32-bit; pc never wraps because the HALT transition precedes it.

## Timing

- Fetch latency: instruction at address A appears in IF_ID with if_id_valid=1 on the edge that samples pc==A; one instruction per unstalled cycle.
- First fetch: load_done sampled on edge N → RUN; IF_ID={RESET_PC, mem[RESET_PC]} after edge N+1.
- Branch: branch_valid on edge N → one bubble after edge N; target instruction valid after edge N+1.
- Stall is level-sensitive, sampled every edge; no cycle limit.
- All outputs registered except load_ready, imem_addr, imem_we, imem_wdata.
- Reset asserted mid-RUN or in HALT: the next edge returns to LOAD; memory contents are not cleared.

## Test plan

- Load mem[0..3]=11,22,33,44, pulse load_done → IF_ID = {0,11},{1,22},{2,33},{3,44} on consecutive cycles, if_id_valid=1, state=01.
- Running at pc=2, stall=1 for 3 cycles → IF_ID={1,22} held, pc=2 throughout; after release, IF_ID={2,33} next edge.
- branch_valid=1, target=0x10, stall=1 together → pc=0x10, if_id_valid=0 for one cycle, then IF_ID={0x10, mem[16]}.
- Run to address 127 → IF_ID={127, mem[127]} valid, state=10 next, if_id_valid=0 after, pc stays frozen.
- branch_target=200 → state=10, halt_err=1, if_id_valid=0; then reset=0 for one edge → state=00, halt_err=0, pc=0, load_ready=1.
- load_valid=1 and load_done=1 on the same edge with addr=0, data=0xAA → mem[0]=0xAA and the first fetched IF_ID={0,0xAA}.
